// File: rtl/sram_state_pkg.sv
// Shared sizing constants for the SRAM page-state block.
// The top-level file honours the SRAM_STATE_ECC_EN macro for the optional ECC store.
package sram_state_pkg;
  localparam int PAGE_W        = 11;
  localparam int NUM_PAGES     = 2048;
  localparam int NUM_PORTS     = 16;
  localparam int ECC_W         = 8;
  localparam int RESERVED_PAGE = NUM_PAGES - 1;
endpackage

// File: rtl/sram_free_list.sv
// Free page allocator: fresh counter first, then a FIFO of recycled pages.
// null_ptr is the page handed out on the next accepted pop.
module sram_free_list #(
  parameter int PAGE_W    = sram_state_pkg::PAGE_W,
  parameter int NUM_PAGES = sram_state_pkg::NUM_PAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pop_en,
  input  logic              push_en,
  input  logic [PAGE_W-1:0] push_page,
  output logic              pop_ok,
  output logic [PAGE_W-1:0] null_ptr,
  output logic [PAGE_W-1:0] free_space
);
  import sram_state_pkg::*;

  // The reserved page doubles as the "fresh pool exhausted" marker and the pool size.
  localparam logic [PAGE_W-1:0] POOL_END = PAGE_W'(RESERVED_PAGE);

  logic [PAGE_W-1:0] fifo_mem [NUM_PAGES];
  logic [PAGE_W-1:0] fresh_q, fresh_d;
  logic [PAGE_W-1:0] head_q, head_d;
  logic [PAGE_W-1:0] tail_q, tail_d;
  logic [PAGE_W-1:0] free_q, free_d;
  logic              fresh_left;
  logic              push_ok;

  always_comb begin
    fresh_left = (fresh_q != POOL_END);
    pop_ok     = pop_en && (free_q != '0);
    push_ok    = push_en && (free_q != POOL_END);
    fresh_d    = fresh_q;
    head_d     = head_q;
    tail_d     = tail_q;
    free_d     = free_q;
    if (pop_ok) begin
      if (fresh_left) fresh_d = fresh_q + 1'b1;
      else            head_d  = head_q + 1'b1;
    end
    if (push_ok) tail_d = tail_q + 1'b1;
    if (pop_ok && !push_ok)      free_d = free_q - 1'b1;
    else if (push_ok && !pop_ok) free_d = free_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[tail_q] <= push_page;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fresh_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      free_q  <= POOL_END;
    end else begin
      fresh_q <= fresh_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      free_q  <= free_d;
    end
  end

  assign null_ptr   = fresh_left ? fresh_q : fifo_mem[head_q];
  assign free_space = free_q;
endmodule

// File: rtl/sram_state.sv
// Per-SRAM page bookkeeping: per-port page counts, write lock, free list and ECC store.
// Define SRAM_STATE_ECC_EN to build the ECC store; otherwise ecc_dout is tied to zero.
module sram_state #(
  parameter int PAGE_W    = sram_state_pkg::PAGE_W,
  parameter int NUM_PAGES = sram_state_pkg::NUM_PAGES,
  parameter int NUM_PORTS = sram_state_pkg::NUM_PORTS,
  parameter int ECC_W     = sram_state_pkg::ECC_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ecc_wr_en,
  input  logic [PAGE_W-1:0]                    ecc_wr_addr,
  input  logic [ECC_W-1:0]                     ecc_din,
  input  logic                                 ecc_rd_en,
  input  logic [PAGE_W-1:0]                    ecc_rd_addr,
  output logic [ECC_W-1:0]                     ecc_dout,
  input  logic                                 wr_op,
  input  logic [$clog2(NUM_PORTS)-1:0]         wr_port,
  input  logic                                 rd_op,
  input  logic [$clog2(NUM_PORTS)-1:0]         rd_port,
  input  logic [PAGE_W-1:0]                    rd_addr,
  output logic [NUM_PORTS-1:0][PAGE_W-1:0]     port_amount,
  input  logic                                 lock_en,
  input  logic                                 lock_dis,
  output logic                                 locking,
  output logic [PAGE_W-1:0]                    null_ptr,
  output logic [PAGE_W-1:0]                    free_space
);
  import sram_state_pkg::*;

  localparam int PORT_W = $clog2(NUM_PORTS);

  logic                              wr_ok;
  logic [NUM_PORTS-1:0][PAGE_W-1:0]  amount_q, amount_d;
  logic                              locking_q, locking_d;

  sram_free_list #(
    .PAGE_W    (PAGE_W),
    .NUM_PAGES (NUM_PAGES)
  ) u_free_list (
    .clk        (clk),
    .rst_n      (rst_n),
    .pop_en     (wr_op),
    .push_en    (rd_op),
    .push_page  (rd_addr),
    .pop_ok     (wr_ok),
    .null_ptr   (null_ptr),
    .free_space (free_space)
  );

  // A port allocating and releasing in the same cycle keeps its count.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic              inc, dec;
    logic [PAGE_W-1:0] amt_d;
    always_comb begin
      inc   = wr_ok && (wr_port == PORT_W'(gi));
      dec   = rd_op && (rd_port == PORT_W'(gi));
      amt_d = amount_q[gi];
      if (inc && !dec)                              amt_d = amount_q[gi] + 1'b1;
      else if (dec && !inc && amount_q[gi] != '0)   amt_d = amount_q[gi] - 1'b1;
    end
    assign amount_d[gi] = amt_d;
  end

  always_comb begin
    locking_d = locking_q;
    if (lock_dis)     locking_d = 1'b0;
    else if (lock_en) locking_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amount_q  <= '0;
      locking_q <= 1'b0;
    end else begin
      amount_q  <= amount_d;
      locking_q <= locking_d;
    end
  end

  assign port_amount = amount_q;
  assign locking     = locking_q;

`ifdef SRAM_STATE_ECC_EN
  logic [ECC_W-1:0] ecc_mem [NUM_PAGES];
  logic [ECC_W-1:0] ecc_dout_q, ecc_dout_d;

  always_ff @(posedge clk) begin
    if (ecc_wr_en) ecc_mem[ecc_wr_addr] <= ecc_din;
  end

  always_comb begin
    ecc_dout_d = ecc_dout_q;
    if (ecc_rd_en) ecc_dout_d = ecc_mem[ecc_rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecc_dout_q <= '0;
    else        ecc_dout_q <= ecc_dout_d;
  end

  assign ecc_dout = ecc_dout_q;
`else
  logic ecc_unused;
  assign ecc_unused = ^{ecc_wr_en, ecc_wr_addr, ecc_din, ecc_rd_en, ecc_rd_addr};
  assign ecc_dout   = '0;
`endif
endmodule

// File: tb/tb_sram_state.sv
// Self-checking bench for sram_state: queue-based page-pool model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sram_state;
  logic              clk;
  logic              rst_n;
  logic              ecc_wr_en;
  logic [10:0]       ecc_wr_addr;
  logic [7:0]        ecc_din;
  logic              ecc_rd_en;
  logic [10:0]       ecc_rd_addr;
  logic [7:0]        ecc_dout;
  logic              wr_op;
  logic [3:0]        wr_port;
  logic              rd_op;
  logic [3:0]        rd_port;
  logic [10:0]       rd_addr;
  logic [15:0][10:0] port_amount;
  logic              lock_en;
  logic              lock_dis;
  logic              locking;
  logic [10:0]       null_ptr;
  logic [10:0]       free_space;

`ifdef SRAM_STATE_ECC_EN
  localparam int EXP_5A = 8'h5A;
  localparam int EXP_A5 = 8'hA5;
`else
  localparam int EXP_5A = 0;
  localparam int EXP_A5 = 0;
`endif

  int errors = 0;
  int checks = 0;

  sram_state dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ecc_wr_en   (ecc_wr_en),
    .ecc_wr_addr (ecc_wr_addr),
    .ecc_din     (ecc_din),
    .ecc_rd_en   (ecc_rd_en),
    .ecc_rd_addr (ecc_rd_addr),
    .ecc_dout    (ecc_dout),
    .wr_op       (wr_op),
    .wr_port     (wr_port),
    .rd_op       (rd_op),
    .rd_port     (rd_port),
    .rd_addr     (rd_addr),
    .port_amount (port_amount),
    .lock_en     (lock_en),
    .lock_dis    (lock_dis),
    .locking     (locking),
    .null_ptr    (null_ptr),
    .free_space  (free_space)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: the free pool is "pages not yet handed out by the fresh counter" plus a
  // queue of released pages; counts are plain integers.
  int       m_fresh;
  int       m_q[$];
  int       m_free;
  int       m_amt[16];
  bit       m_lock;
  int       m_dout;
  logic [7:0] m_ecc [2048];

  task automatic model_reset();
    m_fresh = 0;
    m_q.delete();
    m_free = 2047;
    foreach (m_amt[i]) m_amt[i] = 0;
    m_lock = 1'b0;
    m_dout = 0;
  endtask

  task automatic model_clk();
    bit take, give;
    take = wr_op && (m_free > 0);
    give = rd_op && (m_free < 2047);
    if (take) begin
      if (m_fresh < 2047) m_fresh++;
      else void'(m_q.pop_front());
    end
    if (give) m_q.push_back(int'(rd_addr));
    m_free = m_free + (give ? 1 : 0) - (take ? 1 : 0);
    if (take) m_amt[wr_port]++;
    if (rd_op && m_amt[rd_port] > 0) m_amt[rd_port]--;
    if (lock_dis)     m_lock = 1'b0;
    else if (lock_en) m_lock = 1'b1;
`ifdef SRAM_STATE_ECC_EN
    if (ecc_rd_en) m_dout = int'(m_ecc[ecc_rd_addr]);
    if (ecc_wr_en) m_ecc[ecc_wr_addr] = ecc_din;
`endif
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_clk();
  end

  function automatic int model_null();
    if (m_fresh < 2047) return m_fresh;
    return m_q[0];
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (m_free > 0) chk("null_ptr", 32'(null_ptr), model_null());
      chk("free_space", 32'(free_space), m_free);
      chk("locking", 32'(locking), int'(m_lock));
      chk("ecc_dout", 32'(ecc_dout), m_dout);
      for (int i = 0; i < 16; i++)
        chk($sformatf("port_amount[%0d]", i), 32'(port_amount[i]), m_amt[i]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    ecc_wr_en = 0; ecc_wr_addr = 0; ecc_din = 0; ecc_rd_en = 0; ecc_rd_addr = 0;
    wr_op = 0; wr_port = 0; rd_op = 0; rd_port = 0; rd_addr = 0;
    lock_en = 0; lock_dis = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset null_ptr", 32'(null_ptr), 0);
    chk("reset free_space", 32'(free_space), 2047);
    chk("reset locking", 32'(locking), 0);
    chk("reset ecc_dout", 32'(ecc_dout), 0);
    chk("reset port_amount[0]", 32'(port_amount[0]), 0);
    chk("reset port_amount[15]", 32'(port_amount[15]), 0);

    // Release into a full pool: dropped, counts saturate.
    rd_op = 1; rd_port = 5; rd_addr = 100;
    tick();
    rd_op = 0;
    chk("sat free_space", 32'(free_space), 2047);
    chk("sat port_amount[5]", 32'(port_amount[5]), 0);
    chk("sat null_ptr", 32'(null_ptr), 0);

    // Three allocations on ports 0,1,2.
    wr_op = 1; wr_port = 0;
    tick();
    chk("alloc1 null_ptr", 32'(null_ptr), 1);
    wr_port = 1;
    tick();
    chk("alloc2 null_ptr", 32'(null_ptr), 2);
    wr_port = 2;
    tick();
    wr_op = 0;
    chk("alloc3 null_ptr", 32'(null_ptr), 3);
    chk("alloc3 free_space", 32'(free_space), 2044);
    for (int i = 0; i < 3; i++)
      chk($sformatf("alloc3 port_amount[%0d]", i), 32'(port_amount[i]), 1);

    // ECC store: write, read with one-cycle latency, hold, read-during-write.
    ecc_wr_en = 1; ecc_wr_addr = 7; ecc_din = 8'h5A;
    tick();
    ecc_wr_en = 0; ecc_rd_en = 1; ecc_rd_addr = 7;
    tick();
    ecc_rd_en = 0;
    chk("ecc read", 32'(ecc_dout), EXP_5A);
    tick();
    chk("ecc hold", 32'(ecc_dout), EXP_5A);
    ecc_wr_en = 1; ecc_din = 8'hA5; ecc_rd_en = 1;
    tick();
    ecc_wr_en = 0;
    chk("ecc rdw old", 32'(ecc_dout), EXP_5A);
    tick();
    ecc_rd_en = 0;
    chk("ecc new", 32'(ecc_dout), EXP_A5);

    // Port 3 gets two pages, then allocates and releases in one cycle.
    wr_op = 1; wr_port = 3;
    repeat (2) tick();
    wr_op = 0;
    chk("p3 port_amount", 32'(port_amount[3]), 2);
    wr_op = 1; wr_port = 3; rd_op = 1; rd_port = 3; rd_addr = 0;
    tick();
    wr_op = 0; rd_op = 0;
    chk("same port port_amount[3]", 32'(port_amount[3]), 2);
    chk("same port free_space", 32'(free_space), 2042);
    chk("same port null_ptr", 32'(null_ptr), 6);
    wr_op = 1; wr_port = 4; rd_op = 1; rd_port = 1; rd_addr = 1;
    tick();
    wr_op = 0; rd_op = 0;
    chk("diff port port_amount[4]", 32'(port_amount[4]), 1);
    chk("diff port port_amount[1]", 32'(port_amount[1]), 0);
    chk("diff port free_space", 32'(free_space), 2042);

    // Lock priority.
    lock_en = 1; lock_dis = 1;
    tick();
    chk("lock both", 32'(locking), 0);
    lock_dis = 0;
    tick();
    chk("lock set", 32'(locking), 1);
    lock_en = 0;
    tick();
    chk("lock hold", 32'(locking), 1);

    // Drain the pool: fresh pages 7..2046 then recycled pages 0 and 1.
    wr_op = 1;
    for (int i = 0; i < 2042; i++) begin
      wr_port = 4'(i % 16);
      tick();
    end
    chk("drained free_space", 32'(free_space), 0);
    tick();
    chk("empty wr free_space", 32'(free_space), 0);
    wr_op = 0; rd_op = 1; rd_port = 0; rd_addr = 5;
    tick();
    rd_op = 0;
    chk("recycle free_space", 32'(free_space), 1);
    chk("recycle null_ptr", 32'(null_ptr), 5);
    wr_op = 1; wr_port = 6;
    tick();
    chk("re-drain free_space", 32'(free_space), 0);
    rd_op = 1; rd_port = 2; rd_addr = 9;
    tick();
    wr_op = 0; rd_op = 0;
    chk("empty wr+rd free_space", 32'(free_space), 1);
    chk("empty wr+rd null_ptr", 32'(null_ptr), 9);

    // Asynchronous reset in the middle of an allocation.
    wr_op = 1; wr_port = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst free_space", 32'(free_space), 2047);
    chk("async rst null_ptr", 32'(null_ptr), 0);
    chk("async rst locking", 32'(locking), 0);
    chk("async rst port_amount[3]", 32'(port_amount[3]), 0);
    tick();
    rst_n = 1'b1; wr_op = 0;
    tick();
    chk("post rst null_ptr", 32'(null_ptr), 0);
    wr_op = 1; wr_port = 9;
    tick();
    wr_op = 0;
    chk("post rst alloc null_ptr", 32'(null_ptr), 1);
    chk("post rst port_amount[9]", 32'(port_amount[9]), 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
